// File: rtl/if_fetch_unit_pkg.sv
`timescale 1ns/1ps
// Shared widths, reset PC and the {pc,inst} packet carried toward ID.
// No logic; constants and a PC-increment helper only.
// Imported by the fetch unit, its interface and the bench.
package if_fetch_unit_pkg;

  localparam int               PC_WIDTH     = 32;
  localparam int               INST_WIDTH   = 32;
  localparam int               INST_BYTES   = 4;
  localparam logic [PC_WIDTH-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_pkt_t;

  // Sequential fetch address; wraps modulo 2^PC_WIDTH by truncation.
  function automatic logic [PC_WIDTH-1:0] next_pc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(INST_BYTES);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
`timescale 1ns/1ps
// Bundle of redirect, imem request/response and ID handoff signals.
// master = fetch unit side, slave = controller/memory/ID side.
// Signal names keep the _i/_o sense as seen from the fetch unit.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
  ;
  logic                  flush_i;
  logic [PC_WIDTH-1:0]   flush_pc_i;
  logic                  imem_req_valid_o;
  logic                  imem_req_ready_i;
  logic [PC_WIDTH-1:0]   imem_req_addr_o;
  logic                  imem_rsp_valid_i;
  logic [INST_WIDTH-1:0] imem_rsp_data_i;
  logic                  id_valid_o;
  logic                  id_ready_i;
  logic [PC_WIDTH-1:0]   id_pc_o;
  logic [INST_WIDTH-1:0] id_inst_o;

  modport master (
    input  flush_i, flush_pc_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, id_ready_i,
    output imem_req_valid_o, imem_req_addr_o, id_valid_o, id_pc_o, id_inst_o
  );

  modport slave (
    output flush_i, flush_pc_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, id_ready_i,
    input  imem_req_valid_o, imem_req_addr_o, id_valid_o, id_pc_o, id_inst_o
  );
endinterface

// File: rtl/if_sync_fifo.sv
`timescale 1ns/1ps
// Small register FIFO with synchronous clear and occupancy count.
// Head visible combinationally from registers; push to head takes one edge.
// Push when full / pop when empty are ignored; callers guarantee space.
module if_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output logic [WIDTH-1:0]       o_head_dat,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push  = i_push && (r_count != (AW+1)'(DEPTH));
  assign w_do_pop   = i_pop && (r_count != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Storage, pointers and count; clear empties without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch: owns PC, issues in-order imem requests, pairs returns with PCs.
// Response cycle N -> id_valid_o cycle N+1; request accepted -> PC advances next edge.
// Credit-limited: in-flight + buffered + pending drops never exceed DEPTH.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = DEF_RESET_PC,
  parameter int                  DEPTH    = 2
) (
  input logic              clk,
  input logic              rst,
  if_fetch_unit_if.master  fetch
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_WIDTH-1:0] r_pc;
  logic [CW-1:0]       r_drop_cnt;
  logic [CW-1:0]       w_drop_nxt;
  logic [CW-1:0]       w_inflight_cnt;
  logic [CW-1:0]       w_outbuf_cnt;
  logic [CW+1:0]       w_credit_used;
  logic [CW:0]         w_flush_total;
  logic                w_req_vld;
  logic                w_req_fire;
  logic                w_has_drop;
  logic                w_rsp_accept;
  logic                w_out_pop;
  logic [PC_WIDTH-1:0] w_inflight_pc;
  fetch_pkt_t          w_rsp_pkt;
  fetch_pkt_t          w_head_pkt;

  // Stale responses still occupy memory slots, so pending drops consume credit.
  assign w_credit_used = {2'b00, w_inflight_cnt} + {2'b00, w_outbuf_cnt} + {2'b00, r_drop_cnt};
  assign w_req_vld     = !rst && !fetch.flush_i && (w_credit_used < (CW+2)'(DEPTH));
  assign w_req_fire    = w_req_vld && fetch.imem_req_ready_i;
  assign w_has_drop    = (r_drop_cnt != '0);
  assign w_rsp_accept  = fetch.imem_rsp_valid_i && !w_has_drop &&
                         (w_inflight_cnt != '0) && !fetch.flush_i;
  assign w_out_pop     = (w_outbuf_cnt != '0) && fetch.id_ready_i && !fetch.flush_i;
  assign w_flush_total = {1'b0, r_drop_cnt} + {1'b0, w_inflight_cnt};
  assign w_rsp_pkt     = '{pc: w_inflight_pc, inst: fetch.imem_rsp_data_i};

  assign fetch.imem_req_valid_o = w_req_vld;
  assign fetch.imem_req_addr_o  = r_pc;
  assign fetch.id_valid_o       = (w_outbuf_cnt != '0);
  assign fetch.id_pc_o          = w_head_pkt.pc;
  assign fetch.id_inst_o        = w_head_pkt.inst;

  // PCs of requests accepted by memory, awaiting their responses.
  if_sync_fifo #(.WIDTH(PC_WIDTH), .DEPTH(DEPTH)) u_inflight (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_req_fire),
    .i_push_dat (r_pc),
    .i_pop      (w_rsp_accept),
    .i_clear    (fetch.flush_i),
    .o_head_dat (w_inflight_pc),
    .o_count    (w_inflight_cnt)
  );

  // Completed {pc,inst} pairs waiting for ID.
  if_sync_fifo #(.WIDTH($bits(fetch_pkt_t)), .DEPTH(DEPTH)) u_outbuf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_rsp_accept),
    .i_push_dat (w_rsp_pkt),
    .i_pop      (w_out_pop),
    .i_clear    (fetch.flush_i),
    .o_head_dat (w_head_pkt),
    .o_count    (w_outbuf_cnt)
  );

  // Drop count: on redirect every in-flight request becomes stale; a response
  // arriving in the same cycle consumes one of those slots immediately.
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (fetch.flush_i) begin
      if (fetch.imem_rsp_valid_i && (w_flush_total != '0))
        w_drop_nxt = CW'(w_flush_total - (CW+1)'(1));
      else
        w_drop_nxt = CW'(w_flush_total);
    end else if (fetch.imem_rsp_valid_i && w_has_drop) begin
      w_drop_nxt = r_drop_cnt - CW'(1);
    end
  end

  // PC and drop counter state; redirect overrides sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_nxt;
      if (fetch.flush_i)   r_pc <= fetch.flush_pc_i;
      else if (w_req_fire) r_pc <= next_pc(r_pc);
    end
  end

  // A response with nothing outstanding means the memory broke ordering.
  a_rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    !(fetch.imem_rsp_valid_i && !w_has_drop && (w_inflight_cnt == '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
// Randomized bench for if_fetch_unit with an epoch-tagged reference model.
// Driver issues stimulus and predicts; monitor pops expected ID packets.
// Memory model answers in order with random latency.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int            DEPTH  = 2;
  localparam logic [31:0]   RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus)
  );

  req_t        pending[$];   // requests accepted by memory, oldest first
  fetch_pkt_t  exp_q[$];     // packets that must appear at ID, in order
  int          epoch;
  logic [31:0] model_pc;
  int          n_checks;
  int          n_fail;
  int          p_rdy, p_rsp, p_idr, p_fl;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit roll(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic quiet_inputs();
    bus.flush_i          = 1'b0;
    bus.flush_pc_i       = '0;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = '0;
    bus.id_ready_i       = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_req_valid"}, 64'(bus.imem_req_valid_o), 64'd0);
    check({tag, "_id_valid"},  64'(bus.id_valid_o),       64'd0);
    check({tag, "_id_pc"},     64'(bus.id_pc_o),          64'd0);
    check({tag, "_id_inst"},   64'(bus.id_inst_o),        64'd0);
  endtask

  // One clock cycle of stimulus plus model update.
  task automatic cycle(input bit force_fl, input logic [31:0] force_pc);
    logic        fl;
    logic [31:0] fpc;
    logic [31:0] rnd;
    bit          exp_rv;
    bit          fire;
    req_t        r;
    @(negedge clk);
    rnd = $urandom;
    fl  = force_fl || roll(p_fl);
    case ($urandom_range(2, 0))
      0:       fpc = 32'h0000_0100;
      1:       fpc = 32'hFFFF_FFF8;
      default: fpc = {rnd[31:2], 2'b00};
    endcase
    if (force_fl) fpc = force_pc;
    bus.flush_i          = fl;
    bus.flush_pc_i       = fpc;
    bus.imem_req_ready_i = roll(p_rdy);
    bus.imem_rsp_valid_i = (pending.size() > 0) && roll(p_rsp);
    bus.imem_rsp_data_i  = bus.imem_rsp_valid_i ? inst_of(pending[0].addr) : $urandom;
    bus.id_ready_i       = roll(p_idr);
    #1;
    exp_rv = !fl && ((pending.size() + exp_q.size()) < DEPTH);
    check("req_valid", 64'(bus.imem_req_valid_o), 64'(exp_rv));
    if (exp_rv) check("req_addr", 64'(bus.imem_req_addr_o), 64'(model_pc));
    fire = exp_rv && bus.imem_req_ready_i;
    if (fire) pending.push_back('{addr: model_pc, epoch: epoch});
    #2;
    if (bus.imem_rsp_valid_i) begin
      r = pending.pop_front();
      if (!fl && r.epoch == epoch) exp_q.push_back('{pc: r.addr, inst: inst_of(r.addr)});
    end
    if (fl) begin
      exp_q.delete();
      epoch++;
      model_pc = fpc;
    end else if (fire) begin
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  task automatic phase(input int rdy, input int rsp, input int idr, input int fl);
    p_rdy = rdy; p_rsp = rsp; p_idr = idr; p_fl = fl;
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic mid_reset();
    @(negedge clk);
    quiet_inputs();
    #4;
    rst = 1'b1;
    #0.5;
    check_cleared("async_rst");
    pending.delete();
    exp_q.delete();
    epoch++;
    model_pc = RST_PC;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle, compare ID presentation against the expected queue.
  initial begin
    fetch_pkt_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("id_valid", 64'(bus.id_valid_o), 64'(exp_q.size() > 0));
        if (bus.id_valid_o && bus.id_ready_i && !bus.flush_i && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("id_pc",   64'(bus.id_pc_o),   64'(e.pc));
          check("id_inst", 64'(bus.id_inst_o), 64'(e.inst));
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    epoch    = 0;
    model_pc = RST_PC;
    quiet_inputs();
    phase(100, 100, 100, 0);
    #2;
    check_cleared("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Streaming, then ID stall and release.
    phase(100, 100, 100, 0);  run(40);
    phase(100, 100, 0, 0);    run(10);
    phase(100, 100, 100, 0);  run(10);
    // Slow memory with redirects to exercise drop accounting.
    phase(100, 40, 100, 0);   run(6);
    cycle(1'b1, 32'h0000_0100);
    run(20);
    // Request stall, redirect while stalled.
    phase(0, 100, 100, 0);    run(5);
    cycle(1'b1, 32'h0000_0200);
    phase(100, 100, 100, 0);  run(10);
    // Address wrap.
    cycle(1'b1, 32'hFFFF_FFFC);
    run(10);
    // Random mixes.
    phase(80, 50, 70, 8);     run(400);
    phase(30, 60, 60, 15);    run(300);
    phase(90, 90, 90, 30);    run(200);
    // Reset in the middle of traffic.
    phase(100, 60, 80, 0);    run(15);
    mid_reset();
    phase(100, 100, 100, 0);  run(30);
    phase(70, 50, 50, 5);     run(200);
    phase(100, 100, 100, 0);  run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the pipeline controller.
- Owns the architectural fetch PC and issues in-order requests to instruction memory over a valid/ready channel.
- Pairs each returned instruction with its PC and buffers the pair toward ID.
- On a controller redirect (if_flush/flush_pc), discards all younger in-flight and buffered work and restarts fetch at the redirect PC.

Parameters:
- PC_WIDTH, 32, fetch address width; must equal `PC_WIDTH from defines.v.
- INST_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, capacity of in-flight PC queue and of output buffer; power of two, >=2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush_i  in  1  redirect from controller (if_flush_o).
- flush_pc_i  in  PC_WIDTH  redirect target (flush_pc_o).
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  PC_WIDTH  fetch address (= pc_q).
- imem_rsp_valid_i  in  1  instruction returned; in order; no backpressure.
- imem_rsp_data_i  in  INST_WIDTH  returned instruction.
- id_valid_o  out  1  instruction available for ID.
- id_ready_i  in  1  ID accepts.
- id_pc_o  out  PC_WIDTH  PC of head instruction.
- id_inst_o  out  INST_WIDTH  head instruction.

Behaviour:
- Reset (async):
  - pc_q=RESET_PC.
  - Both queues empty; drop_cnt=0.
  - imem_req_valid_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
- Request issue (credit scheme):
  - imem_req_valid_o = !flush_i && (inflight_cnt + outbuf_cnt + drop_cnt) < DEPTH.
  - Handshake (valid&&ready):
    - push pc_q into in-flight queue;
    - pc_q <= pc_q + 4, wrapping modulo 2^PC_WIDTH.
  - Address is held stable while valid && !ready.
- Response:
  - imem_rsp_valid_i with drop_cnt>0: decrement drop_cnt; data discarded.
  - Otherwise: pop in-flight head, push {pc,inst} into output buffer.
  - The credit scheme guarantees space; a response with empty in-flight queue and drop_cnt==0 is a protocol error, ignored, and flagged by assertion.
- Output:
  - id_valid_o = outbuf non-empty; id_pc_o/id_inst_o show the head entry, registered (no combinational path from imem_rsp).
  - Pop on id_valid_o && id_ready_i.
  - Push and pop in the same cycle is legal; occupancy is unchanged.
  - Minimum latency: response in cycle N -> id_valid_o in cycle N+1.
- Flush (flush_i=1), takes effect at the next edge:
  - pc_q <= flush_pc_i.
  - Output buffer cleared; an ID pop that cycle is irrelevant.
  - drop_cnt <= drop_cnt + inflight_cnt, minus 1 if a response is being dropped this cycle. A response arriving in the flush cycle is itself discarded and decrements whichever count it consumes.
  - In-flight queue cleared.
  - No request is issued in the flush cycle.
  - id_valid_o=0 the cycle after flush.
  - Flush on consecutive cycles: last flush_pc_i wins; drop_cnt accounting stays exact.
- Requests resume the cycle after flush, if credit allows (drop_cnt consumes credit).
- Counters are $clog2(DEPTH)+1 bits wide; none may exceed DEPTH.

Decomposition:
- Shared package/defines: PC_WIDTH, INST_WIDTH, RESET_PC, INST_BYTES=4.
- One sub-module: if_sync_fifo (parameterised width/depth, push/pop/clear, count).
  - Instantiated twice: the in-flight PC queue (width PC_WIDTH) and the output buffer (width PC_WIDTH+INST_WIDTH).

Test Plan:
- Reset, then imem ready=1, 1-cycle response latency, id_ready=1 -> addresses 0x0,0x4,0x8… issued; ID receives the matching pc/inst pairs in order, one per cycle sustained.
- id_ready=0 for 10 cycles -> at most 2 requests outstanding+buffered; req_valid drops; no instruction lost; release gives PCs 0x0,0x4 then 0x8.
- Two requests in flight (0x10,0x14), flush_i with flush_pc=0x100 -> both responses discarded; next ID instruction has pc=0x100; next request addr=0x100.
- Response arrives in the same cycle as flush (one other in flight) -> neither reaches ID; drop_cnt returns to 0 after the second response.
- imem_req_ready=0 for 5 cycles -> addr held at 0x20, valid stays high; a flush during the stall -> addr becomes flush_pc next cycle, nothing dropped.
- Start at pc 0xFFFF_FFFC -> next request addr 0x0 (wrap).
- Async rst asserted mid-stream -> outputs clear immediately; after release, fetch restarts at RESET_PC; no stale response reaches ID.
